// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter that shares one single-ported memory between an
// instruction-fetch port (i*) and a data load/store port (d*).
//
// Ports
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   iReq, iAddr          fetch request and byte address
//   iRData, iDone        fetch data (valid while iDone) and completion pulse
//   dReq, dAddr          data request and byte address
//   dWData, dWMask       store data and byte mask (mask 0 = load)
//   dRData, dDone        load data (valid while dDone) and completion pulse
//   memAddr, memRstrb    shared-memory address and read strobe
//   memWData, memWMask   shared-memory write data and byte write mask
//   memRData             memory read data, valid the cycle after the strobe edge
//   busy                 high whenever an access is in flight
//   dbgState             current FSM state (0 idle, 1 issue, 2 resp)
//
// Handshake: a requester raises Req with stable fields and keeps it high
// until its Done pulse. Done is high for exactly one cycle and read data is
// valid only in that cycle. A Req still high in the cycle after Done is a
// new request. Request fields are captured at the grant edge, so later
// changes have no effect on the access in flight.
//
// Every access takes IDLE (arbitrate) -> ISSUE (drive memory) -> RESP (Done).
module mem_arbiter #(
    parameter int RR = 1  // 1: round-robin on ties, 0: data port wins ties
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic [31:0] iRData,
    output logic        iDone,
    input  logic        dReq,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    input  logic [3:0]  dWMask,
    output logic [31:0] dRData,
    output logic        dDone,
    output logic [31:0] memAddr,
    output logic        memRstrb,
    output logic [31:0] memWData,
    output logic [3:0]  memWMask,
    input  logic [31:0] memRData,
    output logic        busy,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   grantD;  // port owning the current access: 1 = data, 0 = instruction
    logic   lastD;   // port granted most recently, drives round-robin ties
    logic   pickD;   // arbitration result for the current IDLE cycle

    // Without a tie the requesting port wins; on a tie the data port wins
    // unless round-robin is enabled and it was also the last one served.
    always_comb begin
        pickD = 1'b0;
        if (dReq) begin
            pickD = !iReq || (RR == 0) || !lastD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            grantD   <= 1'b0;
            lastD    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            memWMask <= '0;
            memRstrb <= 1'b0;
            iDone    <= 1'b0;
            dDone    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iReq || dReq) begin
                        grantD   <= pickD;
                        lastD    <= pickD;
                        // The memory-side registers double as the request latch.
                        memAddr  <= pickD ? dAddr : iAddr;
                        memWData <= pickD ? dWData : 32'h0;
                        memWMask <= pickD ? dWMask : 4'h0;
                        memRstrb <= !pickD || (dWMask == 4'h0);
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The memory acts on this edge; the response arrives in RESP.
                    memAddr  <= '0;
                    memWData <= '0;
                    memWMask <= '0;
                    memRstrb <= 1'b0;
                    iDone    <= !grantD;
                    dDone    <= grantD;
                    state    <= RESP;
                end
                RESP: begin
                    iDone <= 1'b0;
                    dDone <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    memAddr  <= '0;
                    memWData <= '0;
                    memWMask <= '0;
                    memRstrb <= 1'b0;
                    iDone    <= 1'b0;
                    dDone    <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Read data is a straight pass-through from the memory during RESP only.
    assign iRData   = (state == RESP && !grantD) ? memRData : 32'h0;
    assign dRData   = (state == RESP &&  grantD) ? memRData : 32'h0;
    assign dbgState = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives mem_arbiter (round-robin instance) with directed and randomized
// requests against a transaction-level model and a behavioural memory, and
// a second data-priority instance with a held tie.
module tb_mem_arbiter;

    localparam int RR_T = 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic resetn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (round-robin) ----------------
    logic        iReq, iDone, dReq, dDone, memRstrb, busy;
    logic [31:0] iAddr, iRData, dAddr, dWData, dRData;
    logic [31:0] memAddr, memWData, memRData;
    logic [3:0]  dWMask, memWMask;
    logic [1:0]  dbgState;

    mem_arbiter #(.RR(RR_T)) dut (
        .clk(clk), .resetn(resetn),
        .iReq(iReq), .iAddr(iAddr), .iRData(iRData), .iDone(iDone),
        .dReq(dReq), .dAddr(dAddr), .dWData(dWData), .dWMask(dWMask),
        .dRData(dRData), .dDone(dDone),
        .memAddr(memAddr), .memRstrb(memRstrb), .memWData(memWData),
        .memWMask(memWMask), .memRData(memRData),
        .busy(busy), .dbgState(dbgState)
    );

    // ---------------- DUT (data priority) ----------------
    logic        ziReq, ziDone, zdReq, zdDone, zMemRstrb, zBusy;
    logic [31:0] ziAddr, ziRData, zdAddr, zdWData, zdRData;
    logic [31:0] zMemAddr, zMemWData, zMemRData;
    logic [3:0]  zdWMask, zMemWMask;
    logic [1:0]  zDbg;

    mem_arbiter #(.RR(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .iReq(ziReq), .iAddr(ziAddr), .iRData(ziRData), .iDone(ziDone),
        .dReq(zdReq), .dAddr(zdAddr), .dWData(zdWData), .dWMask(zdWMask),
        .dRData(zdRData), .dDone(zdDone),
        .memAddr(zMemAddr), .memRstrb(zMemRstrb), .memWData(zMemWData),
        .memWMask(zMemWMask), .memRData(zMemRData),
        .busy(zBusy), .dbgState(zDbg)
    );

    // ---------------- behavioural memory ----------------
    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (memWMask != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (memWMask[b]) mem[memAddr[9:2]][8*b +: 8] = memWData[8*b +: 8];
        end
        memRData <= memRstrb ? mem[memAddr[9:2]] : $urandom();
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One access in flight at most; mLeft counts the cycles still to show:
    // 2 = memory being driven, 1 = completion cycle, 0 = nothing in flight.
    int          mLeft = 0;
    bit          mOwnD = 1'b0;
    bit          mLastD = 1'b0;
    logic [31:0] mAddr = '0, mWData = '0, mRd = '0;
    logic [3:0]  mMask = '0;
    logic [31:0] refMem [256];

    // Advance the model across the coming rising edge using the inputs as
    // they are right now.
    task automatic modelNext();
        logic [7:0] idx;
        if (!resetn) begin
            mLeft  = 0;
            mLastD = 1'b0;
        end else if (mLeft == 2) begin
            idx = mAddr[9:2];
            if (mMask == 4'h0) mRd = refMem[idx];
            else
                for (int b = 0; b < 4; b++)
                    if (mMask[b]) refMem[idx][8*b +: 8] = mWData[8*b +: 8];
            mLeft = 1;
        end else if (mLeft == 1) begin
            mLeft = 0;
        end else if (iReq || dReq) begin
            if (iReq && dReq) mOwnD = (RR_T == 0) ? 1'b1 : ~mLastD;
            else              mOwnD = dReq;
            mLastD = mOwnD;
            mAddr  = mOwnD ? dAddr  : iAddr;
            mWData = mOwnD ? dWData : 32'h0;
            mMask  = mOwnD ? dWMask : 4'h0;
            mLeft  = 2;
        end
    endtask

    // The single per-cycle comparison of the round-robin DUT against the model.
    task automatic compare();
        bit          drv, rsp;
        logic [31:0] rexp;
        drv  = (mLeft == 2);
        rsp  = (mLeft == 1);
        rexp = (mMask == 4'h0) ? mRd : memRData;
        chk("busy",     busy,     32'(mLeft != 0));
        chk("dbg_idle", 32'(dbgState == 2'd0), 32'(mLeft == 0));
        chk("memAddr",  memAddr,  drv ? mAddr : 32'h0);
        chk("memWData", memWData, drv ? mWData : 32'h0);
        chk("memWMask", memWMask, drv ? mMask : 4'h0);
        chk("memRstrb", memRstrb, 32'(drv && mMask == 4'h0));
        chk("iDone",    iDone,    32'(rsp && !mOwnD));
        chk("dDone",    dDone,    32'(rsp && mOwnD));
        chk("iRData",   iRData,   (rsp && !mOwnD) ? rexp : 32'h0);
        chk("dRData",   dRData,   (rsp && mOwnD) ? rexp : 32'h0);
    endtask

    task automatic tick();
        modelNext();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    // ---------------- driver tasks ----------------
    task automatic doReset();
        resetn = 1'b0;
        iReq   = 1'b0;
        dReq   = 1'b0;
        #1;
        chk("rst_busy",   busy,     32'h0);
        chk("rst_strobe", memRstrb, 32'h0);
        chk("rst_wmask",  memWMask, 32'h0);
        chk("rst_addr",   memAddr,  32'h0);
        chk("rst_wdata",  memWData, 32'h0);
        chk("rst_idone",  iDone,    32'h0);
        chk("rst_ddone",  dDone,    32'h0);
        chk("rst_irdata", iRData,   32'h0);
        chk("rst_drdata", dRData,   32'h0);
        mLeft  = 0;
        mLastD = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic newI();
        iReq  = 1'b1;
        iAddr = $urandom();
    endtask

    task automatic newD();
        dReq   = 1'b1;
        dAddr  = $urandom();
        dWData = $urandom();
        dWMask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endtask

    // ---------------- main sequence ----------------
    int  doneAt[$];
    bit  doneD[$];
    int  zdCnt, ziCnt, zBusyCnt;

    initial begin
        resetn = 1'b0;
        iReq = 1'b0; iAddr = '0;
        dReq = 1'b0; dAddr = '0; dWData = '0; dWMask = '0;
        ziReq = 1'b0; ziAddr = 32'h0; zdReq = 1'b0; zdAddr = 32'h20;
        zdWData = 32'h0; zdWMask = 4'h0; zMemRData = 32'h5A5A_5A5A;
        memRData = '0;
        for (int k = 0; k < 256; k++) begin
            mem[k] = $urandom();
            refMem[k] = mem[k];
        end
        mem[4]  = 32'h0000_0013; refMem[4]  = 32'h0000_0013;
        mem[8]  = 32'hCAFE_0008; refMem[8]  = 32'hCAFE_0008;
        mem[16] = 32'hBEEF_0010; refMem[16] = 32'hBEEF_0010;
        mem[64] = 32'h1122_3344; refMem[64] = 32'h1122_3344;

        @(negedge clk);
        doReset();

        // isolated fetch
        iReq = 1'b1; iAddr = 32'h0000_0010;
        tick();
        chk("fetch_strobe", memRstrb, 32'h1);
        chk("fetch_addr",   memAddr,  32'h10);
        tick();
        chk("fetch_done",   iDone,    32'h1);
        chk("fetch_data",   iRData,   32'h13);
        iReq = 1'b0;
        tick();
        chk("fetch_strobe_once", memRstrb, 32'h0);

        // store then load, partial byte mask
        dReq = 1'b1; dAddr = 32'h100; dWMask = 4'b0011; dWData = 32'hAABB_CCDD;
        tick();
        chk("store_mask",   memWMask, 32'h3);
        chk("store_nostrb", memRstrb, 32'h0);
        tick();
        chk("store_done",   dDone,    32'h1);
        dReq = 1'b0; dWMask = 4'h0;
        tick();
        dReq = 1'b1; dAddr = 32'h100;
        tick();
        chk("load_strobe",  memRstrb, 32'h1);
        tick();
        chk("load_done",    dDone,    32'h1);
        chk("load_data",    dRData,   32'h1122_CCDD);
        dReq = 1'b0;
        tick();

        // address change after the grant edge
        dReq = 1'b1; dAddr = 32'h20;
        tick();
        dAddr = 32'h40;
        #1;
        chk("latch_addr",   memAddr,  32'h20);
        tick();
        chk("latch_data",   dRData,   32'hCAFE_0008);
        dReq = 1'b0;
        tick();

        // reset while a fetch is being issued, then a fresh fetch
        iReq = 1'b1; iAddr = 32'h10;
        tick();
        chk("abort_strobe_pre", memRstrb, 32'h1);
        doReset();
        chk("abort_no_done", iDone, 32'h0);
        iReq = 1'b1; iAddr = 32'h10;
        tick();
        tick();
        chk("abort_fresh_done", iDone,  32'h1);
        chk("abort_fresh_data", iRData, 32'h13);
        iReq = 1'b0;
        tick();

        // held tie from reset, round-robin
        doReset();
        iReq = 1'b1; iAddr = 32'h10; dReq = 1'b1; dAddr = 32'h20; dWMask = 4'h0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (dDone) begin doneAt.push_back(c); doneD.push_back(1'b1); end
            if (iDone) begin doneAt.push_back(c); doneD.push_back(1'b0); end
        end
        iReq = 1'b0; dReq = 1'b0;
        tick();
        chk("rr_count", 32'(doneAt.size()), 32'd4);
        if (doneAt.size() == 4) begin
            chk("rr_first_d",  32'(doneD[0]), 32'h1);
            chk("rr_second_i", 32'(doneD[1]), 32'h0);
            chk("rr_third_d",  32'(doneD[2]), 32'h1);
            chk("rr_fourth_i", 32'(doneD[3]), 32'h0);
            chk("rr_first_at", 32'(doneAt[0]), 32'd2);
            for (int k = 1; k < 4; k++)
                chk("rr_spacing", 32'(doneAt[k] - doneAt[k-1]), 32'd3);
        end

        // held tie, data priority instance
        ziReq = 1'b1; zdReq = 1'b1;
        zdCnt = 0; ziCnt = 0; zBusyCnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (zdDone) begin
                zdCnt++;
                chk("pri_data", zdRData, 32'h5A5A_5A5A);
            end
            if (ziDone) ziCnt++;
            if (zBusy) zBusyCnt++;
            chk("pri_dbg",   32'(zDbg != 2'd0), 32'(zBusy));
            chk("pri_irdat", ziRData,   32'h0);
            chk("pri_wmask", zMemWMask, 32'h0);
            chk("pri_addr",  zMemAddr,  zMemRstrb ? 32'h20 : 32'h0);
            chk("pri_wdata", zMemWData, 32'h0);
        end
        ziReq = 1'b0; zdReq = 1'b0;
        chk("pri_d_count", 32'(zdCnt), 32'd4);
        chk("pri_i_count", 32'(ziCnt), 32'd0);
        chk("pri_busy",    32'(zBusyCnt), 32'd8);
        chk("pri_iaddr_unused", ziAddr, 32'h0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                if (iDone) begin
                    if ($urandom_range(0, 1) == 0) iReq = 1'b0;
                    else newI();
                end else if (!iReq) begin
                    if ($urandom_range(0, 2) == 0) newI();
                end else if (mLeft != 0 && !mOwnD) begin
                    iAddr = $urandom();
                end
                if (dDone) begin
                    if ($urandom_range(0, 1) == 0) dReq = 1'b0;
                    else newD();
                end else if (!dReq) begin
                    if ($urandom_range(0, 2) == 0) newD();
                end else if (mLeft != 0 && mOwnD) begin
                    dAddr  = $urandom();
                    dWData = $urandom();
                    dWMask = 4'($urandom_range(0, 15));
                end
                tick();
            end
        end
        iReq = 1'b0; dReq = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
